// File: rtl/lt_link_spi_master.sv
// lt_link_spi_master: mode-0 SPI master that sends 40-bit register read/write frames to the
// LT24 link slave and returns the 32-bit readback word. Define LT_LINK_SINT_EN to enable the SINT -> irq path.
module lt_link_spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [6:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    input  logic        spi_sint,
    output logic        irq
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [6:0] EDGE_LAST = 7'd79;

    logic [2:0]  state;
    logic [7:0]  div_cnt;
    logic [6:0]  edge_cnt;
    logic [39:0] tx_sr;
    logic [31:0] rx_sr;
    logic        sclk_q;
    logic        cs_n_q;
    logic        div_done;

    assign div_done  = (div_cnt == DIV_LAST);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign spi_sclk  = sclk_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = ~cs_n_q & tx_sr[39];

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;

            if (state == ST_IDLE || div_done) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    edge_cnt <= '0;
                    if (cmd_valid) begin
                        tx_sr  <= {cmd_write, cmd_addr, cmd_write ? cmd_wdata : 32'h0};
                        cs_n_q <= 1'b0;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (div_done) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Sample at the end of the first high cycle, well clear of the slave's falling-edge update.
                    if (sclk_q && div_cnt == '0) begin
                        rx_sr <= {rx_sr[30:0], spi_miso};
                    end
                    if (div_done) begin
                        if (edge_cnt == EDGE_LAST) begin
                            edge_cnt <= '0;
                            sclk_q   <= 1'b0;
                            state    <= ST_HOLD;
                        end else begin
                            edge_cnt <= edge_cnt + 7'd1;
                            sclk_q   <= ~sclk_q;
                            if (sclk_q) begin
                                tx_sr <= {tx_sr[38:0], 1'b0};
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (div_done) begin
                        cs_n_q    <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rx_sr;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (div_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    sclk_q <= 1'b0;
                    cs_n_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef LT_LINK_SINT_EN
    logic [2:0] sint_sync;
    logic       irq_q;

    // Two synchronizer stages plus one history stage for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sint_sync <= '0;
            irq_q     <= 1'b0;
        end else begin
            sint_sync <= {sint_sync[1:0], spi_sint};
            irq_q     <= sint_sync[1] & ~sint_sync[2];
        end
    end

    assign irq = irq_q;
`else
    logic unused_sint;

    assign unused_sint = spi_sint;
    assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_lt_link_spi_master.sv
// Self-checking bench for lt_link_spi_master (CLK_DIV=4): scoreboard of expected frames/readback
// against a mode-0 slave model, plus reset, back-to-back, abort and irq scenarios.
module tb_lt_link_spi_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_sint;
    logic        irq;

    lt_link_spi_master #(.CLK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_sint  (spi_sint),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] frame;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Mode-0 slave model: loads its reply on CS fall, shifts on SCLK fall, captures MOSI on SCLK rise.
    logic [31:0] slave_word = 32'h0;
    logic [39:0] slave_sr   = 40'h0;
    logic [39:0] slave_rx   = 40'h0;
    int          frame_rises = 0;
    int          total_rises = 0;
    int          rv_total    = 0;

    assign spi_miso = slave_sr[39];

    always @(negedge spi_cs_n) begin
        slave_sr    = {8'h00, slave_word};
        slave_rx    = '0;
        frame_rises = 0;
    end

    always @(posedge spi_sclk) begin
        slave_rx = {slave_rx[38:0], spi_mosi};
        frame_rises++;
        total_rises++;
    end

    always @(negedge spi_sclk) slave_sr = {slave_sr[38:0], 1'b0};

    always @(posedge clk) if (rsp_valid === 1'b1) rv_total++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Drives one command, then watches it cycle by cycle until cmd_ready returns.
    task automatic run_cmd(input logic wr, input logic [6:0] addr, input logic [31:0] wdata,
                           input logic [31:0] sword, input bit hold, output int wait_cycles);
        exp_t        e;
        bit          accepted = 0;
        int          ready_k = 0, cs_high_k = 0, rv_k = 0, rv_cnt = 0;
        int          first_sclk_k = 0, last_sclk_k = 0, cs_low_cnt = 0, mosi_bad = 0;
        int          rises_at_rv = 0;
        logic        cs_k1 = 1'b1;
        logic [31:0] rd_seen = '0;
        logic [39:0] fr_seen = '0;

        slave_word = sword;
        cmd_write  = wr;
        cmd_addr   = addr;
        cmd_wdata  = wdata;
        cmd_valid  = 1'b1;
        e.frame = {wr, addr, wr ? wdata : 32'h0};
        e.rdata = sword;
        sb_q.push_back(e);

        wait_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            if (cmd_ready === 1'b1) begin
                accepted = 1;
                break;
            end
            wait_cycles++;
            @(negedge clk);
        end
        if (!accepted) begin
            $display("FAIL accept: cmd_ready never rose, observed 0 expected 1");
            $fatal(1, "command accept timeout");
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;

        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (k == 1) cs_k1 = spi_cs_n;
            if (spi_cs_n === 1'b0) cs_low_cnt++;
            else begin
                if (cs_high_k == 0) cs_high_k = k;
                if (spi_mosi !== 1'b0) mosi_bad++;
            end
            if (spi_sclk === 1'b1) begin
                if (first_sclk_k == 0) first_sclk_k = k;
                last_sclk_k = k;
            end
            if (rsp_valid === 1'b1) begin
                rv_cnt++;
                if (rv_k == 0) begin
                    rv_k        = k;
                    rd_seen     = rsp_rdata;
                    fr_seen     = slave_rx;
                    rises_at_rv = frame_rises;
                    if (sb_q.size() > 0) e = sb_q.pop_front();
                end
            end
            if (cmd_ready === 1'b1) begin
                ready_k = k;
                break;
            end
        end

        check("cs_fall_T+1",      64'(cs_k1),        64'(0));
        check("cs_low_cycles",    64'(cs_low_cnt),   64'(328));
        check("cs_rise_cycle",    64'(cs_high_k),    64'(329));
        check("first_sclk_rise",  64'(first_sclk_k), 64'(9));
        check("last_sclk_high",   64'(last_sclk_k),  64'(324));
        check("rsp_valid_cycle",  64'(rv_k),         64'(329));
        check("rsp_valid_pulses", 64'(rv_cnt),       64'(1));
        check("cmd_ready_cycle",  64'(ready_k),      64'(333));
        check("cs_gap_ge_4",      64'((ready_k - cs_high_k + 1) >= 4), 64'(1));
        check("mosi_idle_zero",   64'(mosi_bad),     64'(0));
        check("sclk_rises",       64'(rises_at_rv),  64'(40));
        check("mosi_frame",       64'(fr_seen),      64'(e.frame));
        check("rsp_rdata",        64'(rd_seen),      64'(e.rdata));
    endtask

    int wait_cycles;
    int rv_before;
    int irq_cnt;
    int irq_first;
    bit reached;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        spi_sint  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_cs_n",      64'(spi_cs_n),  64'(1));
        check("rst_sclk",      64'(spi_sclk),  64'(0));
        check("rst_mosi",      64'(spi_mosi),  64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_irq",       64'(irq),       64'(0));

        repeat (1000) @(negedge clk);
        check("idle_no_sclk", 64'(total_rises), 64'(0));

        // Write: expected MOSI stream 0x95A5C30F01.
        run_cmd(1'b1, 7'h15, 32'hA5C3_0F01, 32'h0BAD_F00D, 1'b0, wait_cycles);
        // Read: header 0x02 then 32 zeros, slave returns 0x12345678.
        run_cmd(1'b0, 7'h02, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, wait_cycles);

        // Back-to-back with cmd_valid held: second accept must be immediate when cmd_ready returns.
        run_cmd(1'b0, 7'h7F, 32'h0, 32'hCAFE_F00D, 1'b1, wait_cycles);
        run_cmd(1'b1, 7'h40, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0, wait_cycles);
        check("b2b_accept_wait", 64'(wait_cycles), 64'(0));

        // Abort mid-frame at the 20th SCLK rise.
        slave_word = 32'h5555_AAAA;
        cmd_write  = 1'b1;
        cmd_addr   = 7'h33;
        cmd_wdata  = 32'hDEAD_BEEF;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rv_before = rv_total;
        reached   = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (frame_rises >= 20) begin
                reached = 1;
                break;
            end
        end
        check("abort_reached_edge20", 64'(frame_rises), 64'(20));
        rst = 1'b1;
        #1;
        check("abort_cs_n",      64'(spi_cs_n),  64'(1));
        check("abort_sclk",      64'(spi_sclk),  64'(0));
        check("abort_mosi",      64'(spi_mosi),  64'(0));
        check("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        check("abort_busy",      64'(busy),      64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        check("abort_no_rsp_valid", 64'(rv_total - rv_before), 64'(0));
        check("abort_rdata_kept_reset", 64'(rsp_rdata), 64'(0));

        run_cmd(1'b1, 7'h0C, 32'h0F0F_1234, 32'h8765_4321, 1'b0, wait_cycles);

        // SINT: held high for 50 cycles.
        irq_cnt   = 0;
        irq_first = 0;
        @(posedge clk);
        #1;
        spi_sint = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 50) spi_sint = 1'b0;
            if (irq === 1'b1) begin
                irq_cnt++;
                if (irq_first == 0) irq_first = n;
            end
        end
`ifdef LT_LINK_SINT_EN
        check("irq_pulse_count", 64'(irq_cnt),   64'(1));
        check("irq_delay",       64'(irq_first), 64'(3));
`else
        check("irq_stays_low",   64'(irq_cnt),   64'(0));
        check("irq_level_now",   64'(irq),       64'(0));
`endif

        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
